mc_control_fsm: RTL
===================

MC_CONTROL_FSM -- requirements
Module: mc_control_fsm

Interface
REQ-001 Parameter CNT_W, default 16: width of the retired-instruction counter.
REQ-002 Reset is rst, asynchronous, active-high; the clock is clk.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  asynchronous active-high reset.
REQ-005 opcode  in  6  instruction opcode, IR[31:26], valid from DECODE onward.
REQ-006 zero  in  1  ALU zero flag.
REQ-007 mem_ready  in  1  memory access complete (wait-state handshake).
REQ-008 Outputs, 1 bit each: iord, alusrca, irwrite, memwrite, regwrite, regdst, memtoreg, branch, pc_en. Outputs, 2 bits each: alusrcb, aluop, pcsrc.
REQ-009 state  out  4  current state encoding.
REQ-010 instr_done  out  1  single-cycle pulse when an instruction retires.
REQ-011 illegal_op  out  1  single-cycle pulse when DECODE sees an unsupported opcode.
REQ-012 retire_cnt  out  CNT_W  count of retired instructions.

Function
REQ-013 State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11; codes 12-15 go to FETCH on the next edge.
REQ-014 Transitions: FETCH->DECODE; DECODE dispatches on opcode (100011 or 101011 ->MEMADR, 000000 ->EXECUTE, 000100 ->BRANCH, 001000 ->ADDIEX, 000010 ->JUMP, other ->FETCH).
REQ-015 Further transitions: MEMADR->MEMRD if opcode=100011, else MEMWR; MEMRD->MEMWB; EXECUTE->ALUWB; ADDIEX->ADDIWB; MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB, JUMP ->FETCH.
REQ-016 Outputs are Moore (a function of state only, except pc_en); every output not listed for a state is 0.
REQ-017 FETCH: alusrcb=01, irwrite=1, pcwrite=1.
REQ-018 DECODE: alusrcb=11. MEMADR and ADDIEX: alusrca=1, alusrcb=10.
REQ-019 MEMRD: iord=1. MEMWB: memtoreg=1, regwrite=1. MEMWR: iord=1, memwrite=1.
REQ-020 EXECUTE: alusrca=1, aluop=10. ALUWB: regdst=1, regwrite=1. ADDIWB: regwrite=1.
REQ-021 BRANCH: alusrca=1, aluop=01, pcsrc=01, branch=1. JUMP: pcsrc=10, pcwrite=1.
REQ-022 pc_en = pcwrite OR (branch AND zero), where pcwrite is internal.
REQ-023 instr_done is 1 for exactly the cycle the FSM leaves MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB or JUMP toward FETCH; it is registered and asserted in the following FETCH cycle.
REQ-024 retire_cnt increments by 1 with each instr_done; it wraps from 2^CNT_W-1 to 0 without a flag.
REQ-025 illegal_op pulses in the cycle after DECODE with an unsupported opcode; no retire occurs; the FSM returns to FETCH.

Reset
REQ-026 While rst=1: state=FETCH, retire_cnt=0, instr_done=0, illegal_op=0; Moore outputs show FETCH values.
REQ-027 Reset asserted mid-instruction (including during a wait state) aborts that instruction: no retire and no counter update.

Configuration
REQ-028 With macro MC_MEMWAIT_EN defined: FETCH, MEMRD and MEMWR hold while mem_ready=0 and advance on the edge where mem_ready=1.
REQ-029 With MC_MEMWAIT_EN defined, irwrite and pcwrite in FETCH are gated by mem_ready; memwrite and iord stay asserted throughout the MEMWR and MEMRD holds.
REQ-030 Without MC_MEMWAIT_EN: mem_ready is ignored, each state lasts exactly one cycle, and the port remains present.

Verification
REQ-031 Reset, then lw (100011) with mem_ready=1 -> states 0,1,2,3,4,0; instr_done in the final FETCH; retire_cnt=1.
REQ-032 R-type, then sw -> R-type takes 4 cycles (0,1,6,7) and regdst=1 in ALUWB; sw takes 4 cycles (0,1,2,5) and memwrite=1 in MEMWR only; retire_cnt=2.
REQ-033 beq with zero=1, then beq with zero=0 -> pc_en=1 in BRANCH for the first and pc_en=0 for the second; both retire.
REQ-034 Opcode 111111 -> DECODE->FETCH, one illegal_op pulse, retire_cnt unchanged.
REQ-035 MC_MEMWAIT_EN defined, mem_ready low for 3 cycles in FETCH -> FETCH held 4 cycles, pc_en high only in the final cycle.
REQ-036 Preload retire_cnt to 0xFFFF (CNT_W=16) and retire one j -> retire_cnt=0x0000; rst asserted in MEMRD -> state=0 immediately and no retire.

Source files
------------

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS-style control FSM: Moore datapath controls, retire/illegal pulses.
// Ports: clk, rst (async high), opcode/zero/mem_ready in; controls, state, instr_done, illegal_op, retire_cnt out.
// Optional macro MC_MEMWAIT_EN: FETCH/MEMRD/MEMWR hold until mem_ready.
module mc_control_fsm #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             iord,
  output logic             alusrca,
  output logic             irwrite,
  output logic             memwrite,
  output logic             regwrite,
  output logic             regdst,
  output logic             memtoreg,
  output logic             branch,
  output logic             pc_en,
  output logic [1:0]       alusrcb,
  output logic [1:0]       aluop,
  output logic [1:0]       pcsrc,
  output logic [3:0]       state,
  output logic             instr_done,
  output logic             illegal_op,
  output logic [CNT_W-1:0] retire_cnt
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_e;

  state_e           state_q, state_d;
  logic             instr_done_q, illegal_op_q;
  logic [CNT_W-1:0] retire_cnt_q;
  logic             pcwrite;
  logic             retire;
  logic             illegal;
  logic             rdy;

`ifdef MC_MEMWAIT_EN
  assign rdy = mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign rdy = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_FETCH;
      instr_done_q <= 1'b0;
      illegal_op_q <= 1'b0;
      retire_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      instr_done_q <= retire;
      illegal_op_q <= illegal;
      if (retire)
        retire_cnt_q <= retire_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_comb begin
    state_d  = state_q;
    iord     = 1'b0;
    alusrca  = 1'b0;
    irwrite  = 1'b0;
    memwrite = 1'b0;
    regwrite = 1'b0;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    branch   = 1'b0;
    alusrcb  = 2'b00;
    aluop    = 2'b00;
    pcsrc    = 2'b00;
    pcwrite  = 1'b0;
    retire   = 1'b0;
    illegal  = 1'b0;
    case (state_q)
      S_FETCH: begin
        alusrcb = 2'b01;
        irwrite = rdy;
        pcwrite = rdy;
        if (rdy) state_d = S_DECODE;
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        case (opcode)
          6'b100011,
          6'b101011: state_d = S_MEMADR;
          6'b000000: state_d = S_EXECUTE;
          6'b000100: state_d = S_BRANCH;
          6'b001000: state_d = S_ADDIEX;
          6'b000010: state_d = S_JUMP;
          default: begin
            state_d = S_FETCH;
            illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = (opcode == 6'b100011) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        iord = 1'b1;
        if (rdy) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
        state_d  = S_FETCH;
        retire   = 1'b1;
      end
      S_MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
        if (rdy) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      end
      S_EXECUTE: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
        state_d  = S_FETCH;
        retire   = 1'b1;
      end
      S_BRANCH: begin
        alusrca = 1'b1;
        aluop   = 2'b01;
        pcsrc   = 2'b01;
        branch  = 1'b1;
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = S_ADDIWB;
      end
      S_ADDIWB: begin
        regwrite = 1'b1;
        state_d  = S_FETCH;
        retire   = 1'b1;
      end
      S_JUMP: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      // unused codes 12-15 recover to FETCH with all controls low
      default: state_d = S_FETCH;
    endcase
  end

  assign pc_en      = pcwrite | (branch & zero);
  assign state      = state_q;
  assign instr_done = instr_done_q;
  assign illegal_op = illegal_op_q;
  assign retire_cnt = retire_cnt_q;

endmodule
